dual_issue_scheduler: RTL

- Sits between the two-wide decode stage and execute. Accepts one decoded instruction pair per handshake and issues it in program order to two issue slots.
- Splits a pair when B has a RAW dependence on A, or when both are memory ops (one memory port).
- Inserts a one-cycle bubble on load-use hazards against loads issued in the previous issue cycle.

---
 rtl/issue_pkg.sv | 37 +++
 rtl/issue_hazard_check.sv | 30 +++
 rtl/dual_issue_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared types for the dual-issue scheduler: uop header layout, ctrl bits, FSM states.
package issue_pkg;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMRE    = 4;
    localparam int CTRL_MEMWR    = 3;
    localparam int HDR_W         = 23;
    localparam int DEF_PAYLOAD_W = 49;

    typedef struct packed {
        logic [7:0] ctrls;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [4:0] rd;
    } uop_hdr_t;

    typedef struct packed {
        logic [DEF_PAYLOAD_W-1:0] payload;
        uop_hdr_t                 hdr;
    } uop_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PAIR   = 2'd1,
        ST_B_PEND = 2'd2
    } state_t;

    function automatic logic is_mem(input uop_hdr_t u);
        return u.ctrls[CTRL_MEMRE] | u.ctrls[CTRL_MEMWR];
    endfunction

    // x0 is hardwired, so a zero register never creates a hazard
    function automatic logic reads(input uop_hdr_t u, input logic [4:0] r);
        return (r != 5'd0) && ((u.rs1 == r) || (u.rs2 == r));
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational hazard detection between the buffered pair and recent loads.
module issue_hazard_check
    import issue_pkg::*;
(
    input  uop_hdr_t   a,
    input  uop_hdr_t   b,
    input  logic       ld_v0,
    input  logic [4:0] ld_rd0,
    input  logic       ld_v1,
    input  logic [4:0] ld_rd1,
    output logic       lu_a,
    output logic       lu_b,
    output logic       dep_ba,
    output logic       mem_conflict
);

    logic unused_bits;

    assign lu_a = (ld_v0 && reads(a, ld_rd0))
               || (ld_v1 && reads(a, ld_rd1));
    assign lu_b = (ld_v0 && reads(b, ld_rd0))
               || (ld_v1 && reads(b, ld_rd1));

    assign dep_ba       = a.ctrls[CTRL_REGWRITE] && reads(b, a.rd);
    assign mem_conflict = is_mem(a) && is_mem(b);

    assign unused_bits = ^{b.rd, b.ctrls[7:5], b.ctrls[2:0],
                           a.ctrls[6:5], a.ctrls[2:0]};

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order two-wide issue with RAW/memory pair splitting and load-use bubbles.
// Define ISSUE_PERF_CNT_EN to add the perf_dual/perf_single/perf_bubble counters.
module dual_issue_scheduler
    import issue_pkg::*;
#(
    parameter int PAYLOAD_W = 49,
    parameter int UOP_W     = PAYLOAD_W + 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_b_valid,
    output logic             in_ready,
    input  logic [UOP_W-1:0] in_uop_a,
    input  logic [UOP_W-1:0] in_uop_b,
    input  logic             iss_stall,
    output logic             iss_valid_0,
    output logic [UOP_W-1:0] iss_uop_0,
    output logic             iss_valid_1,
    output logic [UOP_W-1:0] iss_uop_1
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_dual,
    output logic [31:0]      perf_single,
    output logic [31:0]      perf_bubble
`endif
);

    state_t           state, state_nxt;
    logic [UOP_W-1:0] buf_a, buf_b, uop0_nxt;
    logic             buf_b_v;
    logic             ld_v0, ld_v1;
    logic [4:0]       ld_rd0, ld_rd1;
    uop_hdr_t         ha, hb, h0;
    logic             lu_a, lu_b, dep_ba, mem_conflict;
    logic             iss0, iss1, sel_b0, bubble, done;
    logic             accept, ld0_nxt, ld1_nxt;
    logic             unused_h0;

    assign ha = buf_a[HDR_W-1:0];
    assign hb = buf_b[HDR_W-1:0];

    issue_hazard_check u_hz (
        .a            (ha),
        .b            (hb),
        .ld_v0        (ld_v0),
        .ld_rd0       (ld_rd0),
        .ld_v1        (ld_v1),
        .ld_rd1       (ld_rd1),
        .lu_a         (lu_a),
        .lu_b         (lu_b),
        .dep_ba       (dep_ba),
        .mem_conflict (mem_conflict)
    );

    always_comb begin
        iss0      = 1'b0;
        iss1      = 1'b0;
        sel_b0    = 1'b0;
        bubble    = 1'b0;
        done      = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_EMPTY: done = 1'b1;
            ST_PAIR: begin
                if (lu_a) begin
                    bubble = 1'b1;
                end else if (!buf_b_v) begin
                    iss0 = 1'b1;
                    done = 1'b1;
                end else if (dep_ba || mem_conflict || lu_b) begin
                    iss0      = 1'b1;
                    state_nxt = ST_B_PEND;
                end else begin
                    iss0 = 1'b1;
                    iss1 = 1'b1;
                    done = 1'b1;
                end
            end
            ST_B_PEND: begin
                if (lu_b) begin
                    bubble = 1'b1;
                end else begin
                    iss0   = 1'b1;
                    sel_b0 = 1'b1;
                    done   = 1'b1;
                end
            end
            default: done = 1'b1;
        endcase
    end

    assign uop0_nxt = sel_b0 ? buf_b : buf_a;
    assign h0       = uop0_nxt[HDR_W-1:0];

    // Only register-writing loads can cause a load-use bubble
    assign ld0_nxt = iss0 && h0.ctrls[CTRL_REGWRITE] && h0.ctrls[CTRL_MEMRE];
    assign ld1_nxt = iss1 && hb.ctrls[CTRL_REGWRITE] && hb.ctrls[CTRL_MEMRE];

    assign unused_h0 = ^{h0.rs2, h0.rs1, h0.ctrls[6:5], h0.ctrls[3:0]};

    assign in_ready = !flush && !iss_stall && done;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            buf_a       <= '0;
            buf_b       <= '0;
            buf_b_v     <= 1'b0;
            ld_v0       <= 1'b0;
            ld_v1       <= 1'b0;
            ld_rd0      <= '0;
            ld_rd1      <= '0;
            iss_valid_0 <= 1'b0;
            iss_valid_1 <= 1'b0;
            iss_uop_0   <= '0;
            iss_uop_1   <= '0;
        end else if (flush) begin
            state       <= ST_EMPTY;
            ld_v0       <= 1'b0;
            ld_v1       <= 1'b0;
            iss_valid_0 <= 1'b0;
            iss_valid_1 <= 1'b0;
        end else if (!iss_stall) begin
            iss_valid_0 <= iss0;
            iss_valid_1 <= iss1;
            if (iss0) iss_uop_0 <= uop0_nxt;
            if (iss1) iss_uop_1 <= buf_b;
            ld_v0  <= ld0_nxt;
            ld_rd0 <= h0.rd;
            ld_v1  <= ld1_nxt;
            ld_rd1 <= hb.rd;
            if (accept) begin
                buf_a   <= in_uop_a;
                buf_b   <= in_uop_b;
                buf_b_v <= in_b_valid;
                state   <= ST_PAIR;
            end else if (done) begin
                state <= ST_EMPTY;
            end else begin
                state <= state_nxt;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dual   <= '0;
            perf_single <= '0;
            perf_bubble <= '0;
        end else if (!flush && !iss_stall) begin
            if (iss1)      perf_dual   <= perf_dual + 32'd1;
            else if (iss0) perf_single <= perf_single + 32'd1;
            if (bubble)    perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule
